// File: rtl/led_pkg.sv
// Shared definitions for the LED duty ramp: mode encodings, FSM states and
// the square-law gamma table generator used when LED_RAMP_GAMMA_EN is defined.
package led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_FIXED   = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD_HI,
        ST_RAMP_DN,
        ST_HOLD_LO
    } ramp_state_t;

    // Rounded i*i/steps; indices past the top of the range saturate at steps.
    function automatic logic [7:0] gamma_entry(input int unsigned idx, input int unsigned steps);
        int unsigned v;
        if (idx >= steps) begin
            v = steps;
        end else begin
            v = (idx * idx + steps / 2) / steps;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/led_ramp_prescaler.sv
// Ramp tick prescaler: counts 0..STEP_DIV-1 while run is high, held at 0 otherwise.
module led_ramp_prescaler #(
    parameter int unsigned STEP_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = run && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/led_duty_ramp.sv
// Breathing-duty generator for the LED PWM stage; duty commits only on pwm_wrap.
// Optional macro LED_RAMP_GAMMA_EN maps the committed duty through a square-law table.
module led_duty_ramp
    import led_pkg::*;
#(
    parameter int unsigned PWM_STEPS  = 100,
    parameter int unsigned STEP_DIV   = 1_000_000,
    parameter int unsigned STEP_SIZE  = 4,
    parameter int unsigned HOLD_TICKS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] fixed_duty,
    input  logic       pwm_wrap,
    output logic [7:0] duty,
    output logic       duty_upd
);

    localparam logic [7:0] MAX_DUTY = 8'(PWM_STEPS);
    localparam logic [7:0] STEP8    = 8'(STEP_SIZE);
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (HOLD_TICKS > 0) ? HW'(HOLD_TICKS - 1) : '0;

    ramp_state_t   state_reg, state_next;
    logic [7:0]    staged_reg, staged_next;
    logic [HW-1:0] hold_reg, hold_next;

    logic       breathe;
    logic       tick;
    logic [7:0] fixed_clamped;
    logic [7:0] idle_level;
    logic [8:0] sum9;
    logic [7:0] ramp_up_val;
    logic [7:0] duty_mapped;

    assign breathe       = enable && (mode == MODE_BREATHE);
    assign fixed_clamped = (fixed_duty > MAX_DUTY) ? MAX_DUTY : fixed_duty;
    assign idle_level    = (enable && (mode == MODE_FIXED)) ? fixed_clamped : 8'd0;
    // Nine-bit sum so a large step near 255 clamps instead of wrapping.
    assign sum9          = {1'b0, staged_reg} + {1'b0, STEP8};
    assign ramp_up_val   = (sum9 >= {1'b0, MAX_DUTY}) ? MAX_DUTY : sum9[7:0];

    led_ramp_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (breathe),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            staged_reg <= '0;
            hold_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            staged_reg <= staged_next;
            hold_reg   <= hold_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        staged_next = staged_reg;
        hold_next   = hold_reg;
        if (!breathe) begin
            state_next  = ST_IDLE;
            staged_next = idle_level;
            hold_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next  = ST_RAMP_UP;
                    staged_next = '0;
                    hold_next   = '0;
                end
                ST_RAMP_UP: begin
                    if (tick) begin
                        staged_next = ramp_up_val;
                        if (ramp_up_val == MAX_DUTY) begin
                            state_next = (HOLD_TICKS == 0) ? ST_RAMP_DN : ST_HOLD_HI;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (tick) begin
                        if (hold_reg == HOLD_LAST) begin
                            hold_next  = '0;
                            state_next = ST_RAMP_DN;
                        end else begin
                            hold_next = hold_reg + 1'b1;
                        end
                    end
                end
                ST_RAMP_DN: begin
                    if (tick) begin
                        if (staged_reg <= STEP8) begin
                            staged_next = '0;
                            state_next  = (HOLD_TICKS == 0) ? ST_RAMP_UP : ST_HOLD_LO;
                        end else begin
                            staged_next = staged_reg - STEP8;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (tick) begin
                        if (hold_reg == HOLD_LAST) begin
                            hold_next  = '0;
                            state_next = ST_RAMP_UP;
                        end else begin
                            hold_next = hold_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next  = ST_IDLE;
                    staged_next = '0;
                    hold_next   = '0;
                end
            endcase
        end
    end

`ifdef LED_RAMP_GAMMA_EN
    logic [7:0] gamma_lut [0:255];
    for (genvar gi = 0; gi < 256; gi++) begin : g_gamma
        assign gamma_lut[gi] = gamma_entry(gi, PWM_STEPS);
    end
    assign duty_mapped = gamma_lut[staged_reg];
`else
    assign duty_mapped = staged_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            duty     <= '0;
            duty_upd <= 1'b0;
        end else begin
            duty_upd <= pwm_wrap;
            if (pwm_wrap) begin
                duty <= duty_mapped;
            end
        end
    end

endmodule
